// File: rtl/cp0_exc_unit_pkg.sv
// ============================================================================
// Module      : cp0_exc_unit_pkg
// Description : Shared CP0 constants for exception codes and register numbers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_exc_unit_pkg;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // Interrupt mask/pending bits start at this position in SR and Cause
    localparam int IM_LSB = 10;

endpackage

`default_nettype wire

// File: rtl/cp0_exc_unit_if.sv
// ============================================================================
// Module      : cp0_exc_unit_if
// Description : M-stage to CP0 request/response bundle (mfc0/mtc0, traps, eret).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cp0_exc_unit_if #(
    parameter int HWINT_W = 6
);
    logic [4:0]         CP0Addr;
    logic               CP0WE;
    logic [31:0]        CP0In;
    logic [31:0]        VPC;
    logic               BDIn;
    logic [4:0]         ExcCodeIn;
    logic [HWINT_W-1:0] HWInt;
    logic               EXLClr;
    logic [31:0]        CP0Out;
    logic [31:0]        EPCOut;
    logic               Req;

    modport master (
        output CP0Addr, CP0WE, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  CP0Out, EPCOut, Req
    );

    modport slave (
        input  CP0Addr, CP0WE, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output CP0Out, EPCOut, Req
    );
endinterface

`default_nettype wire

// File: rtl/cp0_exc_unit.sv
// ============================================================================
// Module      : cp0_exc_unit
// Description : CP0 exception/interrupt sink: trap decision, SR/Cause/EPC, mfc0/mtc0/eret.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_exc_unit
    import cp0_exc_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2023_0705,
    parameter int          HWINT_W    = 6
) (
    input  wire logic      clk,
    input  wire logic      reset,
    cp0_exc_unit_if.slave  bus
);

    logic [HWINT_W-1:0] sr_im_q;
    logic               sr_exl_q;
    logic               sr_ie_q;
    logic               cause_bd_q;
    logic [HWINT_W-1:0] cause_ip_q;
    logic [4:0]         cause_exc_q;
    logic [31:0]        epc_q;

    logic               w_int_req;
    logic               w_exc_req;
    logic               w_req;
    logic [4:0]         w_exc_code;
    logic [31:0]        epc_d;

    always_comb begin
        w_int_req  = (|(bus.HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
        w_exc_req  = (bus.ExcCodeIn != EXC_INT) & ~sr_exl_q;
        w_req      = (w_int_req | w_exc_req) & ~reset;
        // Asynchronous interrupts take precedence over the M-stage exception
        w_exc_code = w_int_req ? EXC_INT : bus.ExcCodeIn;
        epc_d      = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            cause_ip_q <= bus.HWInt;
            if (w_req) begin
                sr_exl_q    <= 1'b1;
                cause_bd_q  <= bus.BDIn;
                cause_exc_q <= w_exc_code;
                epc_q       <= epc_d;
            end else begin
                if (bus.CP0WE && (bus.CP0Addr == CP0_SR)) begin
                    sr_im_q  <= bus.CP0In[IM_LSB +: HWINT_W];
                    sr_exl_q <= bus.CP0In[1];
                    sr_ie_q  <= bus.CP0In[0];
                end
                if (bus.CP0WE && (bus.CP0Addr == CP0_EPC)) begin
                    epc_q <= bus.CP0In;
                end
                // eret overrides a simultaneous mtc0 for the EXL bit only
                if (bus.EXLClr) begin
                    sr_exl_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.CP0Out = '0;
        case (bus.CP0Addr)
            CP0_SR: begin
                bus.CP0Out[IM_LSB +: HWINT_W] = sr_im_q;
                bus.CP0Out[1]                 = sr_exl_q;
                bus.CP0Out[0]                 = sr_ie_q;
            end
            CP0_CAUSE: begin
                bus.CP0Out[31]                = cause_bd_q;
                bus.CP0Out[IM_LSB +: HWINT_W] = cause_ip_q;
                bus.CP0Out[6:2]               = cause_exc_q;
            end
            CP0_EPC:  bus.CP0Out = epc_q;
            CP0_PRID: bus.CP0Out = PRID_VALUE;
            default:  bus.CP0Out = '0;
        endcase
    end

    assign bus.EPCOut = epc_q;
    assign bus.Req    = w_req;

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_unit.sv
// ============================================================================
// Module      : tb_cp0_exc_unit
// Description : Directed self-checking bench for cp0_exc_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_exc_unit;
    import cp0_exc_unit_pkg::*;

    localparam logic [31:0] C_PRID = 32'h2023_0705;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    cp0_exc_unit_if #(.HWINT_W(6)) bus ();

    cp0_exc_unit #(
        .PRID_VALUE (C_PRID),
        .HWINT_W    (6)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] addr);
        bus.CP0Addr = addr;
        #1;
    endtask

    task automatic idle();
        bus.CP0WE     = 1'b0;
        bus.CP0In     = '0;
        bus.BDIn      = 1'b0;
        bus.ExcCodeIn = EXC_INT;
        bus.EXLClr    = 1'b0;
        bus.CP0Addr   = 5'd0;
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.VPC   = '0;
        bus.HWInt = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;

        // 1: reset state and constant reads
        rd(CP0_SR);    chk("rst_sr",    bus.CP0Out, 32'h0);
        rd(CP0_CAUSE); chk("rst_cause", bus.CP0Out, 32'h0);
        rd(CP0_EPC);   chk("rst_epc",   bus.CP0Out, 32'h0);
        rd(CP0_PRID);  chk("prid",      bus.CP0Out, C_PRID);
        rd(5'd7);      chk("unimpl",    bus.CP0Out, 32'h0);
        chk("rst_req", {31'b0, bus.Req}, 32'h0);

        // 2: overflow, not in delay slot
        bus.ExcCodeIn = EXC_OV; bus.VPC = 32'h3008; #1;
        chk("ov_req", {31'b0, bus.Req}, 32'h1);
        tick(); idle();
        rd(CP0_EPC);   chk("ov_epc",   bus.CP0Out, 32'h3008);
        rd(CP0_CAUSE); chk("ov_cause", bus.CP0Out, 32'h0000_0030);
        rd(CP0_SR);    chk("ov_sr",    bus.CP0Out, 32'h0000_0002);
        chk("ov_epcout", bus.EPCOut, 32'h3008);

        // 3: AdEL in delay slot, then a nested AdES is ignored
        bus.EXLClr = 1'b1; tick(); idle();
        rd(CP0_SR); chk("eret1_sr", bus.CP0Out, 32'h0);
        bus.ExcCodeIn = EXC_ADEL; bus.BDIn = 1'b1; bus.VPC = 32'h3010; #1;
        chk("adel_req", {31'b0, bus.Req}, 32'h1);
        tick(); idle();
        rd(CP0_EPC);   chk("adel_epc",   bus.CP0Out, 32'h300C);
        rd(CP0_CAUSE); chk("adel_cause", bus.CP0Out, 32'h8000_0010);
        bus.ExcCodeIn = EXC_ADES; bus.VPC = 32'h5000; #1;
        chk("nest_req", {31'b0, bus.Req}, 32'h0);
        tick(); idle();
        rd(CP0_EPC);   chk("nest_epc",   bus.CP0Out, 32'h300C);
        rd(CP0_CAUSE); chk("nest_cause", bus.CP0Out, 32'h8000_0010);
        rd(CP0_SR);    chk("nest_sr",    bus.CP0Out, 32'h0000_0002);

        // 4: enable IM[10]/IE, then interrupt beats RI in the same cycle
        bus.CP0WE = 1'b1; bus.CP0Addr = CP0_SR; bus.CP0In = 32'h0000_0401; #1;
        tick(); idle();
        rd(CP0_SR); chk("mtc0_sr", bus.CP0Out, 32'h0000_0401);
        bus.HWInt = 6'b000001; bus.ExcCodeIn = EXC_RI; bus.VPC = 32'h3020; #1;
        chk("int_req", {31'b0, bus.Req}, 32'h1);
        tick(); idle();
        rd(CP0_CAUSE); chk("int_cause", bus.CP0Out, 32'h0000_0400);
        rd(CP0_EPC);   chk("int_epc",   bus.CP0Out, 32'h3020);
        rd(CP0_SR);    chk("int_sr",    bus.CP0Out, 32'h0000_0403);
        chk("int_nest_req", {31'b0, bus.Req}, 32'h0);

        // 5: mtc0 EPC dropped when a trap is taken; eret; plain mtc0 EPC
        bus.EXLClr = 1'b1; bus.HWInt = '0; tick(); idle();
        rd(CP0_CAUSE); chk("ip_clear", bus.CP0Out, 32'h0);
        bus.ExcCodeIn = EXC_RI; bus.VPC = 32'h3040;
        bus.CP0WE = 1'b1; bus.CP0Addr = CP0_EPC; bus.CP0In = 32'h4000; #1;
        chk("drop_req", {31'b0, bus.Req}, 32'h1);
        tick(); idle();
        chk("drop_epcout", bus.EPCOut, 32'h3040);
        rd(CP0_CAUSE); chk("ri_cause", bus.CP0Out, 32'h0000_0028);
        bus.EXLClr = 1'b1; tick(); idle();
        rd(CP0_SR); chk("eret_sr", bus.CP0Out, 32'h0000_0401);
        bus.CP0WE = 1'b1; bus.CP0Addr = CP0_EPC; bus.CP0In = 32'h4000; #1;
        chk("epc_same_cyc", bus.EPCOut, 32'h3040);
        tick(); idle();
        chk("epc_next_cyc", bus.EPCOut, 32'h4000);
        bus.CP0WE = 1'b1; bus.CP0Addr = CP0_CAUSE; bus.CP0In = 32'hFFFF_FFFF; #1;
        tick(); idle();
        rd(CP0_CAUSE); chk("cause_ro", bus.CP0Out, 32'h0000_0028);
        bus.CP0WE = 1'b1; bus.CP0Addr = CP0_SR; bus.CP0In = 32'h0000_0003; bus.EXLClr = 1'b1; #1;
        tick(); idle();
        rd(CP0_SR); chk("exlclr_wins", bus.CP0Out, 32'h0000_0001);

        // 6: reset in the middle of a trap with interrupts pending
        bus.ExcCodeIn = EXC_ADEL; bus.VPC = 32'h3060; #1;
        tick(); idle();
        rd(CP0_SR); chk("pre_rst_sr", bus.CP0Out, 32'h0000_0003);
        bus.HWInt = 6'b111111; reset = 1'b1; bus.ExcCodeIn = EXC_OV; #1;
        chk("rst_req_a", {31'b0, bus.Req}, 32'h0);
        tick();
        chk("rst_req_b", {31'b0, bus.Req}, 32'h0);
        rd(CP0_SR);    chk("rst2_sr",    bus.CP0Out, 32'h0);
        rd(CP0_CAUSE); chk("rst2_cause", bus.CP0Out, 32'h0);
        rd(CP0_EPC);   chk("rst2_epc",   bus.CP0Out, 32'h0);
        reset = 1'b0; bus.HWInt = '0; idle();

        // EPC wraps when a delay-slot trap sits at address 0
        bus.ExcCodeIn = EXC_ADES; bus.BDIn = 1'b1; bus.VPC = 32'h0; #1;
        chk("wrap_req", {31'b0, bus.Req}, 32'h1);
        tick(); idle();
        rd(CP0_EPC);   chk("wrap_epc",   bus.CP0Out, 32'hFFFF_FFFC);
        rd(CP0_CAUSE); chk("wrap_cause", bus.CP0Out, 32'h8000_0014);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
